// File: rtl/obi_vx_bridge_pkg.sv
// Shared types and widths for the OBI -> VX memory bridge.
package obi_vx_bridge_pkg;

  localparam int OBI_DATA_W = 32;
  localparam int OBI_ADDR_W = 32;
  localparam int OBI_BE_W   = 4;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  we;
    logic [OBI_DATA_W-1:0] rdata;
  } slot_t;

endpackage

// File: rtl/obi_to_vx_bridge_if.sv
// Bus interfaces for the bridge: OBI request/response and VX memory request/response.
interface obi_req_if;
  import obi_vx_bridge_pkg::*;
  logic                  req;
  logic                  gnt;
  logic [OBI_ADDR_W-1:0] addr;
  logic                  we;
  logic [OBI_BE_W-1:0]   be;
  logic [OBI_DATA_W-1:0] wdata;

  modport master (output req, addr, we, be, wdata, input gnt);
  modport slave  (input req, addr, we, be, wdata, output gnt);
endinterface

interface obi_rsp_if;
  import obi_vx_bridge_pkg::*;
  logic                  rvalid;
  logic [OBI_DATA_W-1:0] rdata;

  modport master (output rvalid, rdata);
  modport slave  (input rvalid, rdata);
endinterface

interface VX_mem_req_if #(parameter int TAG_W = 2);
  import obi_vx_bridge_pkg::*;
  logic                  valid;
  logic                  ready;
  logic                  rw;
  logic [OBI_BE_W-1:0]   byteen;
  logic [OBI_ADDR_W-1:0] addr;
  logic [OBI_DATA_W-1:0] data;
  logic [TAG_W-1:0]      tag;

  modport master (output valid, rw, byteen, addr, data, tag, input ready);
  modport slave  (input valid, rw, byteen, addr, data, tag, output ready);
endinterface

interface VX_mem_rsp_if #(parameter int TAG_W = 2);
  import obi_vx_bridge_pkg::*;
  logic                  valid;
  logic                  ready;
  logic [OBI_DATA_W-1:0] data;
  logic [TAG_W-1:0]      tag;

  modport master (output valid, data, tag, input ready);
  modport slave  (input valid, data, tag, output ready);
endinterface

// File: rtl/obi_to_vx_bridge_rob.sv
// Reorder buffer: slot array, pointers, done-marking and in-order retire to OBI.
// Optional same-cycle read bypass when OBI_VX_RSP_BYPASS_EN is defined.
module obi_vx_rob
  import obi_vx_bridge_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc,
  input  logic                  alloc_we,
  input  logic                  issue_hs,
  input  logic                  issue_we,
  input  logic [TAG_W-1:0]      issue_tag,
  input  logic                  rsp_valid,
  input  logic [TAG_W-1:0]      rsp_tag,
  input  logic [OBI_DATA_W-1:0] rsp_data,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [CNT_W-1:0]      count,
  output logic                  rvalid,
  output logic [OBI_DATA_W-1:0] rdata
);

  slot_t                 slots_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  rvalid_r;
  logic [OBI_DATA_W-1:0] rdata_r;

  logic [PTR_W-1:0]      rsp_idx_s, wr_idx_s;
  logic                  rsp_ok_s, wr_ok_s, head_rsp_s, retire_s, byp_s;
  logic [OBI_DATA_W-1:0] retire_data_s;
  slot_t                 head_s;

  // Done events from this cycle count toward the head retire so rvalid is only one register late.
  always_comb begin
    rsp_idx_s     = rsp_tag[PTR_W-1:0];
    wr_idx_s      = issue_tag[PTR_W-1:0];
    head_s        = slots_r[rd_ptr_r];
    rsp_ok_s      = rsp_valid && (rsp_tag == TAG_W'(rsp_idx_s)) && slots_r[rsp_idx_s].busy
                    && !slots_r[rsp_idx_s].done && !slots_r[rsp_idx_s].we;
    wr_ok_s       = issue_hs && issue_we;
    head_rsp_s    = rsp_ok_s && (rsp_idx_s == rd_ptr_r);
    retire_s      = head_s.busy && (head_s.done || head_rsp_s || (wr_ok_s && (wr_idx_s == rd_ptr_r)));
    if (head_s.we) begin
      retire_data_s = '0;
    end else if (head_s.done) begin
      retire_data_s = head_s.rdata;
    end else begin
      retire_data_s = rsp_data;
    end
`ifdef OBI_VX_RSP_BYPASS_EN
    byp_s         = head_rsp_s && !rvalid_r;
`else
    byp_s         = 1'b0;
`endif
  end

  // Slot state, pointers, count and the registered OBI response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      if (alloc) begin
        slots_r[wr_ptr_r] <= '{busy: 1'b1, done: 1'b0, we: alloc_we, rdata: '0};
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (wr_ok_s) begin
        slots_r[wr_idx_s].done <= 1'b1;
      end
      if (rsp_ok_s) begin
        slots_r[rsp_idx_s].done  <= 1'b1;
        slots_r[rsp_idx_s].rdata <= rsp_data;
      end
      if (retire_s) begin
        slots_r[rd_ptr_r] <= '0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
      rvalid_r <= retire_s && !byp_s;
      rdata_r  <= (retire_s && !byp_s) ? retire_data_s : '0;
      case ({alloc, retire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign wr_ptr = wr_ptr_r;
  assign count  = count_r;
  assign rvalid = rvalid_r || byp_s;
  assign rdata  = byp_s ? rsp_data : rdata_r;

endmodule

// File: rtl/obi_to_vx_bridge.sv
// OBI responder -> VX memory initiator with DEPTH outstanding, in-order OBI responses.
// Define OBI_VX_RSP_BYPASS_EN for a same-cycle read-response bypass.
module obi_to_vx_bridge
  import obi_vx_bridge_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int TAG_WIDTH_BIT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  obi_req_if.slave      obi_mem_req,
  obi_rsp_if.master     obi_mem_rsp,
  VX_mem_req_if.master  vx_mem_req,
  VX_mem_rsp_if.slave   vx_mem_rsp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                     issue_valid_r, issue_we_r;
  logic [OBI_BE_W-1:0]      issue_be_r;
  logic [OBI_ADDR_W-1:0]    issue_addr_r;
  logic [OBI_DATA_W-1:0]    issue_wdata_r;
  logic [TAG_WIDTH_BIT-1:0] issue_tag_r;

  logic [PTR_W-1:0]         wr_ptr_s;
  logic [CNT_W-1:0]         count_s;
  logic                     vx_hs_s, gnt_s;

  assign vx_hs_s = issue_valid_r && vx_mem_req.ready;
  assign gnt_s   = obi_mem_req.req && (count_s < CNT_W'(DEPTH)) && (!issue_valid_r || vx_hs_s);

  // Single-entry issue register; a new grant may refill it in the cycle it drains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_valid_r <= 1'b0;
      issue_we_r    <= 1'b0;
      issue_be_r    <= '0;
      issue_addr_r  <= '0;
      issue_wdata_r <= '0;
      issue_tag_r   <= '0;
    end else if (gnt_s) begin
      issue_valid_r <= 1'b1;
      issue_we_r    <= obi_mem_req.we;
      issue_be_r    <= obi_mem_req.be;
      issue_addr_r  <= obi_mem_req.addr;
      issue_wdata_r <= obi_mem_req.wdata;
      issue_tag_r   <= TAG_WIDTH_BIT'(wr_ptr_s);
    end else if (vx_hs_s) begin
      issue_valid_r <= 1'b0;
    end else begin
      issue_valid_r <= issue_valid_r;
    end
  end

  assign obi_mem_req.gnt   = gnt_s;
  assign vx_mem_req.valid  = issue_valid_r;
  assign vx_mem_req.rw     = issue_we_r;
  assign vx_mem_req.byteen = issue_be_r;
  assign vx_mem_req.addr   = issue_addr_r;
  assign vx_mem_req.data   = issue_wdata_r;
  assign vx_mem_req.tag    = issue_tag_r;
  assign vx_mem_rsp.ready  = 1'b1;

  obi_vx_rob #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_WIDTH_BIT)
  ) u_rob (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .alloc     (gnt_s),
    .alloc_we  (obi_mem_req.we),
    .issue_hs  (vx_hs_s),
    .issue_we  (issue_we_r),
    .issue_tag (issue_tag_r),
    .rsp_valid (vx_mem_rsp.valid),
    .rsp_tag   (vx_mem_rsp.tag),
    .rsp_data  (vx_mem_rsp.data),
    .wr_ptr    (wr_ptr_s),
    .count     (count_s),
    .rvalid    (obi_mem_rsp.rvalid),
    .rdata     (obi_mem_rsp.rdata)
  );

endmodule

// File: tb/tb_obi_to_vx_bridge.sv
// Directed bench for obi_to_vx_bridge (default build, DEPTH=4, 2-bit tags).
module tb_obi_to_vx_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] ord [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
  logic       exp_rv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  obi_req_if                 obi_req ();
  obi_rsp_if                 obi_rsp ();
  VX_mem_req_if #(.TAG_W(2)) vx_req ();
  VX_mem_rsp_if #(.TAG_W(2)) vx_rsp ();

  obi_to_vx_bridge #(.DEPTH(4), .TAG_WIDTH_BIT(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .obi_mem_req (obi_req),
    .obi_mem_rsp (obi_rsp),
    .vx_mem_req  (vx_req),
    .vx_mem_rsp  (vx_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    obi_req.req   = 1'b0;
    obi_req.we    = 1'b0;
    obi_req.be    = 4'b1111;
    obi_req.addr  = 32'h0;
    obi_req.wdata = 32'h0;
    vx_req.ready  = 1'b1;
    vx_rsp.valid  = 1'b0;
    vx_rsp.tag    = 2'd0;
    vx_rsp.data   = 32'h0;
  endtask

  task automatic pulse_reset();
    nxt();
    idle();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(obi_req.gnt), 32'h0);
    chk("rst_rvalid", 32'(obi_rsp.rvalid), 32'h0);
    chk("rst_rdata", obi_rsp.rdata, 32'h0);
    chk("rst_vx_valid", 32'(vx_req.valid), 32'h0);
    chk("rst_vx_payload", {vx_req.addr[23:0], vx_req.byteen, 1'b0, vx_req.rw, vx_req.tag}, 32'h0);
    chk("rst_vx_data", vx_req.data, 32'h0);
    chk("rst_rsp_ready", 32'(vx_rsp.ready), 32'h1);

    // single read, VX answers the cycle after its request
    nxt(); obi_req.req = 1'b1; obi_req.addr = 32'h100; #1;
    chk("rd_gnt", 32'(obi_req.gnt), 32'h1);
    nxt(); obi_req.req = 1'b0; #1;
    chk("rd_vx_valid", 32'(vx_req.valid), 32'h1);
    chk("rd_vx_addr", vx_req.addr, 32'h100);
    chk("rd_vx_rw_tag", {30'h0, vx_req.rw, vx_req.tag[0]}, 32'h0);
    nxt(); vx_rsp.valid = 1'b1; vx_rsp.tag = 2'd0; vx_rsp.data = 32'hDEADBEEF; #1;
    chk("rd_rvalid_early", 32'(obi_rsp.rvalid), 32'h0);
    nxt(); vx_rsp.valid = 1'b0; #1;
    chk("rd_rvalid", 32'(obi_rsp.rvalid), 32'h1);
    chk("rd_rdata", obi_rsp.rdata, 32'hDEADBEEF);
    nxt(); #1;
    chk("rd_rvalid_pulse", 32'(obi_rsp.rvalid), 32'h0);

    // posted write, second transaction so tag is 1
    nxt(); obi_req.req = 1'b1; obi_req.we = 1'b1; obi_req.be = 4'b0011;
    obi_req.addr = 32'h200; obi_req.wdata = 32'h12345678; #1;
    chk("wr_gnt", 32'(obi_req.gnt), 32'h1);
    nxt(); obi_req.req = 1'b0; obi_req.we = 1'b0; #1;
    chk("wr_vx_valid", 32'(vx_req.valid), 32'h1);
    chk("wr_vx_ctl", {26'h0, vx_req.rw, vx_req.byteen, vx_req.tag[0]}, {26'h0, 1'b1, 4'b0011, 1'b1});
    chk("wr_vx_addr", vx_req.addr, 32'h200);
    chk("wr_vx_data", vx_req.data, 32'h12345678);
    nxt(); #1;
    chk("wr_rvalid", 32'(obi_rsp.rvalid), 32'h1);
    chk("wr_rdata", obi_rsp.rdata, 32'h0);

    // out-of-order: four reads, VX answers tags 3,1,0,2
    pulse_reset();
    nxt(); obi_req.req = 1'b1; obi_req.addr = 32'h300; #1;
    chk("ooo_gnt0", 32'(obi_req.gnt), 32'h1);
    for (int i = 1; i < 4; i++) begin
      nxt(); obi_req.addr = 32'h300 + 32'(4 * i); #1;
      chk("ooo_gnt", 32'(obi_req.gnt), 32'h1);
      chk("ooo_vx_tag", {31'(vx_req.tag), vx_req.valid}, {31'(i - 1), 1'b1});
    end
    nxt(); obi_req.req = 1'b0; #1;
    chk("ooo_vx_tag3", {31'(vx_req.tag), vx_req.valid}, {31'd3, 1'b1});
    for (int j = 0; j < 7; j++) begin
      nxt();
      if (j < 4) begin
        vx_rsp.valid = 1'b1; vx_rsp.tag = ord[j]; vx_rsp.data = 32'hA0 + 32'(ord[j]);
      end else begin
        vx_rsp.valid = 1'b0;
      end
      #1;
      chk("ooo_rvalid", 32'(obi_rsp.rvalid), 32'(exp_rv[j]));
      if (exp_rv[j]) chk("ooo_rdata", obi_rsp.rdata, 32'hA0 + 32'(j - 3));
    end
    nxt(); #1;
    chk("ooo_drained", 32'(obi_rsp.rvalid), 32'h0);

    // full: four grants, then blocked until tag 0 retires
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      nxt(); obi_req.req = 1'b1; obi_req.addr = 32'h400 + 32'(4 * i); #1;
      chk("full_gnt", 32'(obi_req.gnt), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      nxt(); obi_req.addr = 32'h410;
      if (i == 2) begin
        vx_rsp.valid = 1'b1; vx_rsp.tag = 2'd0; vx_rsp.data = 32'hB0;
      end
      #1;
      chk("full_no_gnt", 32'(obi_req.gnt), 32'h0);
      chk("full_no_rvalid", 32'(obi_rsp.rvalid), 32'h0);
    end
    nxt(); vx_rsp.valid = 1'b0; #1;
    chk("full_gnt5", 32'(obi_req.gnt), 32'h1);
    chk("full_rvalid", 32'(obi_rsp.rvalid), 32'h1);
    chk("full_rdata", obi_rsp.rdata, 32'hB0);
    nxt(); obi_req.req = 1'b0; #1;
    chk("full_vx5", {vx_req.addr[29:0], vx_req.tag}, {30'h410, 2'd0});

    // backpressure: ready low for 5 cycles
    pulse_reset();
    vx_req.ready = 1'b0;
    nxt(); obi_req.req = 1'b1; obi_req.addr = 32'h500; #1;
    chk("bp_gnt", 32'(obi_req.gnt), 32'h1);
    for (int i = 0; i < 5; i++) begin
      nxt(); obi_req.addr = 32'h504; #1;
      chk("bp_hold", {vx_req.addr[28:0], vx_req.tag, vx_req.valid}, {29'h500, 2'd0, 1'b1});
      chk("bp_no_gnt", 32'(obi_req.gnt), 32'h0);
    end
    nxt(); vx_req.ready = 1'b1; #1;
    chk("bp_gnt2", 32'(obi_req.gnt), 32'h1);
    nxt(); obi_req.req = 1'b0; #1;
    chk("bp_next", {vx_req.addr[28:0], vx_req.tag, vx_req.valid}, {29'h504, 2'd1, 1'b1});

    // reset mid-flight: stale responses are dropped
    pulse_reset();
    nxt(); obi_req.req = 1'b1; obi_req.addr = 32'h600; #1;
    chk("mid_gnt0", 32'(obi_req.gnt), 32'h1);
    nxt(); obi_req.addr = 32'h604; #1;
    chk("mid_gnt1", 32'(obi_req.gnt), 32'h1);
    nxt(); obi_req.req = 1'b0;
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        vx_rsp.valid = 1'b1; vx_rsp.tag = 2'(i); vx_rsp.data = 32'hC0 + 32'(i);
      end else begin
        vx_rsp.valid = 1'b0;
      end
      #1;
      chk("mid_no_rvalid", 32'(obi_rsp.rvalid), 32'h0);
      chk("mid_vx_idle", 32'(vx_req.valid), 32'h0);
      nxt();
    end
    obi_req.req = 1'b1; obi_req.addr = 32'h700; #1;
    chk("post_gnt", 32'(obi_req.gnt), 32'h1);
    nxt(); obi_req.req = 1'b0; #1;
    chk("post_vx", {vx_req.addr[29:0], vx_req.tag}, {30'h700, 2'd0});
    nxt(); vx_rsp.valid = 1'b1; vx_rsp.tag = 2'd0; vx_rsp.data = 32'h66; #1;
    nxt(); vx_rsp.valid = 1'b0; #1;
    chk("post_rvalid", 32'(obi_rsp.rvalid), 32'h1);
    chk("post_rdata", obi_rsp.rdata, 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
